// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory responder.
//   - state encoding (enum plus plain localparam constants for the FSM)
//   - NOP instruction returned on an erroneous access
//   - default LATENCY / DEPTH_WORDS values
//   - addr_bad(): misaligned or out-of-range word address check
package imem_pkg;

  localparam int unsigned LATENCY_DEF     = 2;
  localparam int unsigned DEPTH_WORDS_DEF = 1024;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // A byte address is unusable if it is not word aligned or its word index
  // falls beyond the stored array.
  function automatic logic addr_bad(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/imem_lat_counter.sv
// imem_lat_counter: loadable down-counter used to time one memory access.
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset (count cleared to 0)
//   load_i     : load load_val_i (takes priority over decrement)
//   load_val_i : value to load
//   dec_i      : decrement by one (saturates at 0)
//   cnt_o      : current count
//   last_o     : count equals 1, i.e. the access completes at this edge
module imem_lat_counter
#(
  parameter int unsigned W = 4
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction memory with a fixed access latency, serving a
// fetch stage that presents its PC continuously on addr.
//
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-low reset (memory contents are kept)
//   addr       : byte address from the PC
//   instr      : instruction word for the captured address
//   imem_ready : instr is valid for the address currently on addr
//   imem_err   : captured address misaligned or out of range (instr = NOP)
//   wr_en/wr_addr/wr_data : word write port for program load
//   dbg_state  : FSM state (S_IDLE/S_BUSY/S_DONE)
//   dbg_cnt    : latency counter of the main access
//
// Handshake: there is no request strobe. Any change of addr (or a write to
// the word being fetched) restarts the access; imem_ready is only high while
// the finished access matches the live addr, so it drops in the same cycle
// the PC moves.
//
// Optional feature: define IMEM_SEQ_PREFETCH_EN to add a one-entry prefetch
// of the next sequential word (A+4) whenever an access of A completes.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned LATENCY     = LATENCY_DEF,     // 1..15
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [31:0] instr,
  output logic        imem_ready,
  output logic        imem_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_cnt
);

  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  logic        cnt_load, cnt_dec, cnt_last;
  logic [3:0]  cnt_load_val, cnt;

  logic        wr_ok, wr_hit, capture, enter_done;

  function automatic logic [31:0] read_word(input logic [31:0] a);
    if (addr_bad(a, DEPTH_WORDS)) begin
      return NOP_INSTR;
    end
    return mem[a[IW+1:2]];
  endfunction

  // Illegal writes are dropped entirely, so they can neither corrupt an
  // aliased word nor restart the current access.
  assign wr_ok  = wr_en && !addr_bad(wr_addr, DEPTH_WORDS);
  assign wr_hit = wr_ok && (wr_addr[31:2] == addr_q[31:2]);

  // IDLE always captures; BUSY/DONE recapture on a PC change or on a write
  // to the word being fetched. The address used is always the live addr.
  assign capture = (state_q == S_IDLE) ||
                   ((state_q != S_IDLE) && ((addr != addr_q) || wr_hit));

  // Memory array has no reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr[IW+1:2]] <= wr_data;
    end
  end

  imem_lat_counter #(.W(4)) u_main_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .last_o     (cnt_last)
  );

`ifdef IMEM_SEQ_PREFETCH_EN
  logic        pf_valid_q, pf_valid_d;
  logic        pf_done_q, pf_done_d;
  logic        pf_err_q, pf_err_d;
  logic [31:0] pf_addr_q, pf_addr_d;
  logic [31:0] pf_instr_q, pf_instr_d;
  logic        pf_load, pf_dec, pf_last;
  logic [3:0]  pf_cnt;
  logic        pf_wr_kill, pf_match;

  assign pf_wr_kill = wr_ok && (wr_addr[31:2] == pf_addr_q[31:2]);
  assign pf_match   = pf_valid_q && !pf_wr_kill && (addr == pf_addr_q);

  imem_lat_counter #(.W(4)) u_pf_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pf_load),
    .load_val_i (LAT4),
    .dec_i      (pf_dec),
    .cnt_o      (pf_cnt),
    .last_o     (pf_last)
  );
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    err_d        = err_q;
    cnt_load     = 1'b0;
    cnt_load_val = LAT4;
    cnt_dec      = 1'b0;

    if (capture) begin
      addr_d   = addr;
      state_d  = S_BUSY;
      cnt_load = 1'b1;
`ifdef IMEM_SEQ_PREFETCH_EN
      if (pf_match) begin
        if (pf_done_q) begin
          state_d      = S_DONE;
          instr_d      = pf_instr_q;
          err_d        = pf_err_q;
          cnt_load_val = 4'd0;
        end else if (pf_last) begin
          // Background access finishes on this very edge.
          state_d      = S_DONE;
          instr_d      = read_word(pf_addr_q);
          err_d        = addr_bad(pf_addr_q, DEPTH_WORDS);
          cnt_load_val = 4'd0;
        end else begin
          // Take over the remaining time of the background access.
          cnt_load_val = pf_cnt - 4'd1;
        end
      end
`endif
    end else if (state_q == S_BUSY) begin
      cnt_dec = 1'b1;
      if (cnt_last) begin
        state_d = S_DONE;
        instr_d = read_word(addr_q);
        err_d   = addr_bad(addr_q, DEPTH_WORDS);
      end
    end
  end

  assign enter_done = (state_d == S_DONE) && ((state_q != S_DONE) || capture);

`ifdef IMEM_SEQ_PREFETCH_EN
  always_comb begin
    pf_valid_d = pf_valid_q;
    pf_done_d  = pf_done_q;
    pf_err_d   = pf_err_q;
    pf_addr_d  = pf_addr_q;
    pf_instr_d = pf_instr_q;
    pf_load    = 1'b0;
    pf_dec     = 1'b0;
    if (enter_done) begin
      pf_valid_d = 1'b1;
      pf_done_d  = 1'b0;
      pf_addr_d  = addr_d + 32'd4;
      pf_load    = 1'b1;
    end else if (capture || pf_wr_kill) begin
      pf_valid_d = 1'b0;
    end else if (pf_valid_q && !pf_done_q) begin
      pf_dec = 1'b1;
      if (pf_last) begin
        pf_done_d  = 1'b1;
        pf_instr_d = read_word(pf_addr_q);
        pf_err_d   = addr_bad(pf_addr_q, DEPTH_WORDS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pf_valid_q <= 1'b0;
      pf_done_q  <= 1'b0;
      pf_err_q   <= 1'b0;
      pf_addr_q  <= '0;
      pf_instr_q <= '0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_done_q  <= pf_done_d;
      pf_err_q   <= pf_err_d;
      pf_addr_q  <= pf_addr_d;
      pf_instr_q <= pf_instr_d;
    end
  end
`else
  logic unused_enter_done;
  assign unused_enter_done = enter_done;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign instr      = instr_q;
  assign imem_err   = err_q;
  assign imem_ready = (state_q == S_DONE) && (addr == addr_q);
  assign dbg_state  = state_q;
  assign dbg_cnt    = cnt;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] instr;
  logic        imem_ready;
  logic        imem_err;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_cnt;

  int vecs = 0;
  int errs = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  imem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .instr      (instr),
    .imem_ready (imem_ready),
    .imem_err   (imem_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dbg_state  (dbg_state),
    .dbg_cnt    (dbg_cnt)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until imem_ready is seen (bounded).
  task automatic wait_ready(input int max_edges, output int edges);
    edges = 0;
    while (edges < max_edges) begin
      tick();
      edges++;
      if (imem_ready) break;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] la [6] = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h40, 32'hFFC};
    logic [31:0] ld [6] = '{32'h00500093, 32'h00100113, 32'h00200193,
                            32'h00400213, 32'h01000293, 32'h7FF00313};
    rst = 1'b0;
    addr = 32'h0;
    tick();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = la[i]; wr_data = ld[i];
      tick();
    end
    wr_en = 1'b0;
    tick();
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got=%0b exp=0", imem_ready); end
    vecs++; if (instr !== 32'h0) begin errs++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
    vecs++; if (imem_err !== 1'b0) begin errs++; $display("FAIL reset_err got=%0b exp=0", imem_err); end
    vecs++; if (dbg_state !== 2'd0) begin errs++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    vecs++; if (dbg_cnt !== 4'd0) begin errs++; $display("FAIL reset_cnt got=%0d exp=0", dbg_cnt); end
  endtask

  task automatic test_release();
    rst = 1'b1;
    tick();   // cycle 1: capture
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL rel_c1_ready got=%0b exp=0", imem_ready); end
    vecs++; if (dbg_state !== 2'd1) begin errs++; $display("FAIL rel_c1_state got=%0d exp=1", dbg_state); end
    vecs++; if (dbg_cnt !== 4'(LAT)) begin errs++; $display("FAIL rel_c1_cnt got=%0d exp=%0d", dbg_cnt, LAT); end
    tick();   // cycle 2
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL rel_c2_ready got=%0b exp=0", imem_ready); end
    tick();   // cycle 3
    vecs++; if (imem_ready !== 1'b1) begin errs++; $display("FAIL rel_c3_ready got=%0b exp=1", imem_ready); end
    vecs++; if (instr !== 32'h00500093) begin errs++; $display("FAIL rel_c3_instr got=%h exp=00500093", instr); end
    vecs++; if (imem_err !== 1'b0) begin errs++; $display("FAIL rel_c3_err got=%0b exp=0", imem_err); end
  endtask

  task automatic test_step();
    int n;
    addr = 32'h4;
    #1;
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL step_drop got=%0b exp=0", imem_ready); end
    wait_ready(20, n);
    vecs++; if (n !== LAT + 1) begin errs++; $display("FAIL step_lat got=%0d exp=%0d", n, LAT + 1); end
    vecs++; if (instr !== 32'h00100113) begin errs++; $display("FAIL step_instr got=%h exp=00100113", instr); end
    tick(); tick();
    vecs++; if (imem_ready !== 1'b1) begin errs++; $display("FAIL step_hold_ready got=%0b exp=1", imem_ready); end
    vecs++; if (instr !== 32'h00100113) begin errs++; $display("FAIL step_hold_instr got=%h exp=00100113", instr); end
  endtask

  task automatic test_redirect();
    int n;
    addr = 32'h8;
    tick();
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL redir_b1 got=%0b exp=0", imem_ready); end
    tick();
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL redir_b2 got=%0b exp=0", imem_ready); end
    addr = 32'h40;
    wait_ready(20, n);
    vecs++; if (n !== LAT + 1) begin errs++; $display("FAIL redir_lat got=%0d exp=%0d", n, LAT + 1); end
    vecs++; if (instr !== 32'h01000293) begin errs++; $display("FAIL redir_instr got=%h exp=01000293", instr); end
  endtask

  task automatic test_err();
    int n;
    logic [31:0] ta [4] = '{32'h6, 32'h1000, 32'hFFC, 32'h3};
    logic        te [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] ti [4] = '{NOP, NOP, 32'h7FF00313, NOP};
    for (int i = 0; i < 4; i++) begin
      addr = ta[i];
      wait_ready(20, n);
      vecs++; if (n !== LAT + 1) begin errs++; $display("FAIL err_lat[%h] got=%0d exp=%0d", ta[i], n, LAT + 1); end
      vecs++; if (imem_err !== te[i]) begin errs++; $display("FAIL err_flag[%h] got=%0b exp=%0b", ta[i], imem_err, te[i]); end
      vecs++; if (instr !== ti[i]) begin errs++; $display("FAIL err_instr[%h] got=%h exp=%h", ta[i], instr, ti[i]); end
    end
  endtask

  task automatic test_write();
    int n;
    addr = 32'h10;
    wait_ready(20, n);
    vecs++; if (instr !== 32'h00400213) begin errs++; $display("FAIL wr_pre_instr got=%h exp=00400213", instr); end
    // misaligned and out-of-range writes are ignored
    wr_en = 1'b1; wr_addr = 32'h12; wr_data = 32'h11111111;
    tick();
    vecs++; if (imem_ready !== 1'b1) begin errs++; $display("FAIL wr_misalign_ready got=%0b exp=1", imem_ready); end
    wr_addr = 32'h1010; wr_data = 32'h22222222;
    tick();
    wr_en = 1'b0;
    vecs++; if (imem_ready !== 1'b1) begin errs++; $display("FAIL wr_oor_ready got=%0b exp=1", imem_ready); end
    addr = 32'h0;
    wait_ready(20, n);
    addr = 32'h10;
    wait_ready(20, n);
    vecs++; if (instr !== 32'h00400213) begin errs++; $display("FAIL wr_ignored_instr got=%h exp=00400213", instr); end
    // real write to the word being held
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL wr_drop got=%0b exp=0", imem_ready); end
    wait_ready(20, n);
    vecs++; if (n !== LAT) begin errs++; $display("FAIL wr_lat got=%0d exp=%0d", n, LAT); end
    vecs++; if (instr !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_instr got=%h exp=deadbeef", instr); end
  endtask

  task automatic test_busy_write();
    int n;
    addr = 32'h8;
    tick();   // capture
    tick();   // count reaches 1
    wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'h12345678;
    tick();   // would complete here; write forces a restart
    wr_en = 1'b0;
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL bw_drop got=%0b exp=0", imem_ready); end
    wait_ready(20, n);
    vecs++; if (n !== LAT) begin errs++; $display("FAIL bw_lat got=%0d exp=%0d", n, LAT); end
    vecs++; if (instr !== 32'h12345678) begin errs++; $display("FAIL bw_instr got=%h exp=12345678", instr); end
  endtask

  task automatic test_back_to_back();
    int n;
    addr = 32'h40;
    wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'hCAFEF00D;
    tick();
    wr_en = 1'b0;
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL b2b_drop got=%0b exp=0", imem_ready); end
    wait_ready(20, n);
    vecs++; if (n !== LAT) begin errs++; $display("FAIL b2b_lat got=%0d exp=%0d", n, LAT); end
    vecs++; if (instr !== 32'h01000293) begin errs++; $display("FAIL b2b_instr got=%h exp=01000293", instr); end
    addr = 32'h8;
    wait_ready(20, n);
    vecs++; if (n !== LAT + 1) begin errs++; $display("FAIL b2b_back_lat got=%0d exp=%0d", n, LAT + 1); end
    vecs++; if (instr !== 32'hCAFEF00D) begin errs++; $display("FAIL b2b_back_instr got=%h exp=cafef00d", instr); end
  endtask

  task automatic test_reset_mid();
    int n;
    addr = 32'h4;
    tick();
    vecs++; if (dbg_state !== 2'd1) begin errs++; $display("FAIL rmid_busy got=%0d exp=1", dbg_state); end
    rst = 1'b0;
    tick();
    vecs++; if (imem_ready !== 1'b0) begin errs++; $display("FAIL rmid_ready got=%0b exp=0", imem_ready); end
    vecs++; if (instr !== 32'h0) begin errs++; $display("FAIL rmid_instr got=%h exp=00000000", instr); end
    vecs++; if (imem_err !== 1'b0) begin errs++; $display("FAIL rmid_err got=%0b exp=0", imem_err); end
    vecs++; if (dbg_state !== 2'd0) begin errs++; $display("FAIL rmid_state got=%0d exp=0", dbg_state); end
    rst = 1'b1;
    wait_ready(20, n);
    vecs++; if (n !== LAT + 1) begin errs++; $display("FAIL rmid_lat got=%0d exp=%0d", n, LAT + 1); end
    vecs++; if (instr !== 32'h00100113) begin errs++; $display("FAIL rmid_mem got=%h exp=00100113", instr); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_release();
    test_step();
    test_redirect();
    test_err();
    test_write();
    test_busy_write();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
